ddr_read_config_mc: RTL and testbench
=====================================

// Module: ddr_read_config_mc
// PURPOSE
//  Multi-channel DDR read-command generator between the instruction dispatcher and NUM_CH DDR read masters.
//  Decodes one read instruction into a config (st_addr/burst/step/burst_num) for the channel selected by buf_id.
//  Splits linear transfers longer than MAX_BURST into consecutive sub-bursts, each held valid until accepted.
//  Forwards each accepted instruction to the data-receive module through a one-entry handshake slot.
// PARAMETERS
//  NUM_CH       2    number of DDR read channels (>=2)
//  INST_W       64   instruction width
//  DDR_ADDR_W   32   DDR address width
//  BURST_W      16   burst length / count width
//  TD_RATE      2    tail/data beat ratio applied to p_size when opcode[1]=1
//  MAX_BURST    256  max beats per issued linear config (power of 2, <=2^BURST_W-1)
//  ADDR_STRIDE  1    address increment per beat when advancing to next sub-burst
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 synchronous active-high reset
//  in_img_width   in   8                 input image width (global reg)
//  out_img_width  in   8                 output image width (global reg)
//  in_ch_seg      in   4                 input channel segments
//  out_ch_seg     in   4                 output channel segments
//  ins_valid      in   1                 instruction valid
//  ins_ready      out  1                 instruction ready
//  ins            in   INST_W            instruction
//  rx_ins_valid   out  1                 forwarded instruction valid
//  rx_ins_ready   in   1                 forwarded instruction ready
//  rx_ins         out  INST_W            forwarded instruction (registered copy)
//  conf_valid     out  NUM_CH            per-channel config valid
//  conf_ready     in   NUM_CH            per-channel config ready
//  conf_st_addr   out  NUM_CH*DDR_ADDR_W start address, channel c at [c*DDR_ADDR_W +: DDR_ADDR_W]
//  conf_burst     out  NUM_CH*BURST_W    beats per burst
//  conf_step      out  NUM_CH*DDR_ADDR_W address step between bursts
//  conf_burst_num out  NUM_CH*BURST_W    burst count (IMG mode) else 0
//  busy           out  1                 state != IDLE
// BEHAVIOUR
//  Fields: opcode[61:58] buf_id[57:52] row_num[47:44] pix_num[43:40] size[39:32] p_size[51:40] st_addr[31:0].
//  Channel ch = buf_id mod NUM_CH (low $clog2(NUM_CH) bits; ch>=NUM_CH maps to ch-NUM_CH... i.e. modulo).
//  Modes: 00xx IMG-in: burst=((pix_num+1)*in_ch_seg)<<5, step=((pix_num+1)*in_img_width)<<5, burst_num=row_num.
//   10xx IMG-out: same with out_ch_seg/out_img_width. 0100 LIN: len=size+1. 0101-0111 LIN: len=opcode[1]?p_size*TD_RATE:p_size.
//   LIN: step=0, burst_num=0. 11xx: no config, instruction still forwarded. LIN len=0: no config issued.
//  Arithmetic at full precision (>=16 bits), truncated to BURST_W/DDR_ADDR_W on output only.
//  FSM IDLE->CALC->ISSUE->IDLE. ins_ready = (state==IDLE) && !rx_ins_valid; handshake latches ins, enters CALC.
//  CALC (1 cycle): compute fields, rem=len. To IDLE if no config due, else ISSUE.
//  ISSUE: conf_valid[ch]=1, all other bits 0; burst=min(rem,MAX_BURST). Fields stable while valid && !ready.
//   On conf_ready[ch]: rem-=burst, st_addr+=burst*ADDR_STRIDE; rem==0 -> IDLE, else next sub-burst next cycle (valid stays 1).
//  Latency: conf_valid rises 2 cycles after ins handshake; back-to-back sub-bursts at 1/cycle under ready=1.
//  rx slot: rx_ins_valid set the cycle after ins handshake, cleared on rx_ins_ready; independent of ISSUE progress.
//   Next instruction waits for both IDLE and empty rx slot; simultaneous clear+IDLE lets ins_ready rise next cycle.
//  conf_ready on a non-selected channel is ignored. ins_valid in non-IDLE ignored (no accept).
//  Reset (any state, mid-ISSUE included): state IDLE, conf_valid=0, rx_ins_valid=0, busy=0, all fields 0, rem=0;
//   ins_ready=1 from first cycle after reset deasserts.
// CONFIGURATION
//  DDR_RD_CONF_PERF_EN defined: adds out ports perf_ins_cnt[31:0] (accepted instructions) and perf_stall_cnt[31:0]
//   (cycles in ISSUE with conf_valid[ch] && !conf_ready[ch]); both reset to 0, saturate at 2^32-1.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 op 0100 size=9 buf_id=1 ready=1 -> conf_valid[1] 2 cyc after accept, st_addr=A, burst=10, step=0, burst_num=0.
//  2 op 0000 pix=1 row=3 in_ch_seg=2 in_img_width=8 buf_id=0 -> ch0 burst=128 step=512 burst_num=3, single config.
//  3 op 0110 p_size=300 TD_RATE=2 ch1 MAX_BURST=256 -> 3 configs burst 256,256,88, addr A, A+256, A+512.
//  4 hold conf_ready=0 10 cyc in ISSUE -> fields stable, ins_ready=0; PERF_EN: perf_stall_cnt=10.
//  5 rx_ins_ready=0 while config done -> ins_ready stays 0 until rx handshake; op 1100 -> no conf_valid, rx forwarded.
//  6 rst pulse mid sub-burst 2 of case 3 -> conf_valid=0 next cycle, ins_ready=1 after release, no further configs.

Source files
------------

// File: rtl/ddr_read_config_mc.sv
// ---------------------------------------------------------------------------
// ddr_read_config_mc
//
// Multi-channel DDR read-command generator. One read instruction from the
// dispatcher is decoded into a (st_addr, burst, step, burst_num) config for
// the DDR read channel selected by buf_id. Linear transfers longer than
// MAX_BURST are issued as back-to-back sub-bursts. Every accepted
// instruction is also forwarded to the data-receive module through a
// one-entry valid/ready slot.
//
// Optional feature macro: DDR_RD_CONF_PERF_EN
//   When defined, adds perf_ins_cnt (accepted instructions) and
//   perf_stall_cnt (ISSUE cycles with valid && !ready), both saturating.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_img_width/out_img_width, in_ch_seg/out_ch_seg   global image regs
//   ins_valid/ins_ready/ins  instruction input handshake
//   rx_ins_valid/rx_ins_ready/rx_ins   forwarded instruction slot
//   conf_valid/conf_ready    per-channel config handshake
//   conf_st_addr/conf_burst/conf_step/conf_burst_num   packed per channel,
//                            channel c at [c*W +: W]
//   perf_ins_cnt/perf_stall_cnt   (DDR_RD_CONF_PERF_EN only)
//   busy                     FSM not idle
// ---------------------------------------------------------------------------
module ddr_read_config_mc #(
   parameter int NUM_CH      = 2,
   parameter int INST_W      = 64,
   parameter int DDR_ADDR_W  = 32,
   parameter int BURST_W     = 16,
   parameter int TD_RATE     = 2,
   parameter int MAX_BURST   = 256,
   parameter int ADDR_STRIDE = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   in_img_width,
   input  logic [7:0]                   out_img_width,
   input  logic [3:0]                   in_ch_seg,
   input  logic [3:0]                   out_ch_seg,
   input  logic                         ins_valid,
   output logic                         ins_ready,
   input  logic [INST_W-1:0]            ins,
   output logic                         rx_ins_valid,
   input  logic                         rx_ins_ready,
   output logic [INST_W-1:0]            rx_ins,
   output logic [NUM_CH-1:0]            conf_valid,
   input  logic [NUM_CH-1:0]            conf_ready,
   output logic [NUM_CH*DDR_ADDR_W-1:0] conf_st_addr,
   output logic [NUM_CH*BURST_W-1:0]    conf_burst,
   output logic [NUM_CH*DDR_ADDR_W-1:0] conf_step,
   output logic [NUM_CH*BURST_W-1:0]    conf_burst_num,
`ifdef DDR_RD_CONF_PERF_EN
   output logic [31:0]                  perf_ins_cnt,
   output logic [31:0]                  perf_stall_cnt,
`endif
   output logic                         busy
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   // Clamp a remaining beat count to the largest legal single burst.
   function automatic logic [31:0] min_burst(input logic [31:0] r);
      if (r > 32'(MAX_BURST)) begin
         min_burst = 32'(MAX_BURST);
      end else begin
         min_burst = r;
      end
   endfunction

   state_t                  state_q, state_d;
   logic [INST_W-1:0]       ins_q, ins_d;
   logic                    rx_valid_q, rx_valid_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [DDR_ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]             rem_q, rem_d;
   logic [31:0]             burst_q, burst_d;
   logic [DDR_ADDR_W-1:0]   step_q, step_d;
   logic [BURST_W-1:0]      bnum_q, bnum_d;

   logic                    accept_s;
   logic                    ch_ready_s;
   logic [31:0]             rem_next_s;

   // decoded fields of the latched instruction
   logic [3:0]              opcode_s;
   logic [5:0]              buf_id_s;
   logic [3:0]              row_s;
   logic [3:0]              pix_s;
   logic [7:0]              size_s;
   logic [11:0]             p_size_s;
   logic [31:0]             st_addr_s;
   logic [31:0]             pix_p1_s;
   logic [31:0]             calc_burst_s;
   logic [31:0]             calc_rem_s;
   logic [31:0]             calc_step_s;
   logic                    calc_issue_s;

   assign accept_s   = ins_valid && ins_ready;
   assign ch_ready_s = conf_ready[ch_q];
   assign rem_next_s = rem_q - burst_q;

   assign opcode_s  = ins_q[61:58];
   assign buf_id_s  = ins_q[57:52];
   assign p_size_s  = ins_q[51:40];
   assign row_s     = ins_q[47:44];
   assign pix_s     = ins_q[43:40];
   assign size_s    = ins_q[39:32];
   assign st_addr_s = ins_q[31:0];
   assign pix_p1_s  = {28'd0, pix_s} + 32'd1;

   // Instruction decode: all arithmetic kept at 32 bits, truncated only at the ports.
   always_comb begin
      calc_burst_s = 32'd0;
      calc_rem_s   = 32'd0;
      calc_step_s  = 32'd0;
      calc_issue_s = 1'b0;
      case (opcode_s[3:2])
         2'b00: begin
            calc_burst_s = (pix_p1_s * {28'd0, in_ch_seg}) << 5;
            calc_step_s  = (pix_p1_s * {24'd0, in_img_width}) << 5;
            // image configs are one burst: rem==burst finishes on first accept
            calc_rem_s   = calc_burst_s;
            calc_issue_s = 1'b1;
         end
         2'b10: begin
            calc_burst_s = (pix_p1_s * {28'd0, out_ch_seg}) << 5;
            calc_step_s  = (pix_p1_s * {24'd0, out_img_width}) << 5;
            calc_rem_s   = calc_burst_s;
            calc_issue_s = 1'b1;
         end
         2'b01: begin
            if (opcode_s[1:0] == 2'b00) begin
               calc_rem_s = {24'd0, size_s} + 32'd1;
            end else if (opcode_s[1]) begin
               calc_rem_s = {20'd0, p_size_s} * 32'(TD_RATE);
            end else begin
               calc_rem_s = {20'd0, p_size_s};
            end
            calc_burst_s = min_burst(calc_rem_s);
            calc_issue_s = (calc_rem_s != 32'd0);
         end
         default: begin
            calc_issue_s = 1'b0;
         end
      endcase
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (calc_issue_s) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (ch_ready_s && (rem_next_s == 32'd0)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath next-state: latch, decode into config, advance sub-bursts.
   always_comb begin
      ins_d   = ins_q;
      ch_d    = ch_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      burst_d = burst_q;
      step_d  = step_q;
      bnum_d  = bnum_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               ins_d = ins;
            end else begin
               ins_d = ins_q;
            end
         end
         ST_CALC: begin
            ch_d    = CH_W'(buf_id_s % 6'(NUM_CH));
            addr_d  = DDR_ADDR_W'(st_addr_s);
            rem_d   = calc_rem_s;
            burst_d = calc_burst_s;
            step_d  = DDR_ADDR_W'(calc_step_s);
            if (opcode_s[3:2] == 2'b01) begin
               bnum_d = {BURST_W{1'b0}};
            end else begin
               bnum_d = {{(BURST_W-4){1'b0}}, row_s};
            end
         end
         ST_ISSUE: begin
            // fields only move on acceptance, so they hold while stalled
            if (ch_ready_s) begin
               rem_d   = rem_next_s;
               addr_d  = addr_q + DDR_ADDR_W'(burst_q * 32'(ADDR_STRIDE));
               burst_d = min_burst(rem_next_s);
            end else begin
               rem_d   = rem_q;
            end
         end
         default: begin
            rem_d = rem_q;
         end
      endcase
   end

   // Forwarding slot: filled on accept, drained by rx_ins_ready.
   always_comb begin
      if (accept_s) begin
         rx_valid_d = 1'b1;
      end else if (rx_valid_q && rx_ins_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ins_q      <= {INST_W{1'b0}};
         rx_valid_q <= 1'b0;
         ch_q       <= {CH_W{1'b0}};
         addr_q     <= {DDR_ADDR_W{1'b0}};
         rem_q      <= 32'd0;
         burst_q    <= 32'd0;
         step_q     <= {DDR_ADDR_W{1'b0}};
         bnum_q     <= {BURST_W{1'b0}};
      end else begin
         state_q    <= state_d;
         ins_q      <= ins_d;
         rx_valid_q <= rx_valid_d;
         ch_q       <= ch_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         burst_q    <= burst_d;
         step_q     <= step_d;
         bnum_q     <= bnum_d;
      end
   end

   // FSM outputs: config driven only on the selected channel while issuing.
   always_comb begin
      ins_ready      = (state_q == ST_IDLE) && !rx_valid_q && !rst;
      busy           = (state_q != ST_IDLE);
      rx_ins_valid   = rx_valid_q;
      rx_ins         = ins_q;
      conf_valid     = {NUM_CH{1'b0}};
      conf_st_addr   = {(NUM_CH*DDR_ADDR_W){1'b0}};
      conf_burst     = {(NUM_CH*BURST_W){1'b0}};
      conf_step      = {(NUM_CH*DDR_ADDR_W){1'b0}};
      conf_burst_num = {(NUM_CH*BURST_W){1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         if ((state_q == ST_ISSUE) && (ch_q == CH_W'(c))) begin
            conf_valid[c]                                = 1'b1;
            conf_st_addr[c*DDR_ADDR_W +: DDR_ADDR_W]     = addr_q;
            conf_burst[c*BURST_W +: BURST_W]             = BURST_W'(burst_q);
            conf_step[c*DDR_ADDR_W +: DDR_ADDR_W]        = step_q;
            conf_burst_num[c*BURST_W +: BURST_W]         = bnum_q;
         end else begin
            conf_valid[c] = 1'b0;
         end
      end
   end

`ifdef DDR_RD_CONF_PERF_EN
   logic [31:0] perf_ins_q;
   logic [31:0] perf_stall_q;

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ins_q   <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         if (accept_s && (perf_ins_q != 32'hFFFF_FFFF)) begin
            perf_ins_q <= perf_ins_q + 32'd1;
         end else begin
            perf_ins_q <= perf_ins_q;
         end
         if ((state_q == ST_ISSUE) && !ch_ready_s && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end else begin
            perf_stall_q <= perf_stall_q;
         end
      end
   end

   assign perf_ins_cnt   = perf_ins_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ddr_read_config_mc.sv
module tb_ddr_read_config_mc;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_img_width, out_img_width;
   logic [3:0]   in_ch_seg, out_ch_seg;
   logic         ins_valid, ins_ready;
   logic [63:0]  ins;
   logic         rx_ins_valid, rx_ins_ready;
   logic [63:0]  rx_ins;
   logic [1:0]   conf_valid, conf_ready;
   logic [63:0]  conf_st_addr, conf_step;
   logic [31:0]  conf_burst, conf_burst_num;
   logic         busy;
`ifdef DDR_RD_CONF_PERF_EN
   logic [31:0]  perf_ins_cnt, perf_stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_sent  = 0;

   always #5 clk = ~clk;

   ddr_read_config_mc dut (
      .clk(clk), .rst(rst),
      .in_img_width(in_img_width), .out_img_width(out_img_width),
      .in_ch_seg(in_ch_seg), .out_ch_seg(out_ch_seg),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
      .rx_ins_valid(rx_ins_valid), .rx_ins_ready(rx_ins_ready), .rx_ins(rx_ins),
      .conf_valid(conf_valid), .conf_ready(conf_ready),
      .conf_st_addr(conf_st_addr), .conf_burst(conf_burst),
      .conf_step(conf_step), .conf_burst_num(conf_burst_num),
`ifdef DDR_RD_CONF_PERF_EN
      .perf_ins_cnt(perf_ins_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
      .busy(busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [3:0] op, input logic [5:0] buf_id,
                                      input logic [11:0] p_size, input logic [7:0] size,
                                      input logic [31:0] addr);
      return {2'b00, op, buf_id, p_size, size, addr};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction, wait (bounded) for ready, return just after the accept edge.
   task automatic send(input logic [63:0] w);
      int guard = 0;
      ins       = w;
      ins_valid = 1'b1;
      while (!ins_ready && guard < 100) begin
         step();
         guard++;
      end
      check_eq("send_ready", {63'd0, ins_ready}, 64'd1);
      @(posedge clk);
      #1;
      ins_valid = 1'b0;
      n_sent++;
   endtask

   // Compare the full config of channel c against expected values.
   task automatic check_conf(input string tag, input int c, input logic [31:0] addr,
                             input logic [15:0] burst, input logic [31:0] stp,
                             input logic [15:0] bnum);
      logic [1:0] vexp;
      vexp = 2'b00;
      vexp[c] = 1'b1;
      check_eq({tag, "_valid"}, {62'd0, conf_valid}, {62'd0, vexp});
      check_eq({tag, "_addr"},  {32'd0, conf_st_addr[c*32 +: 32]}, {32'd0, addr});
      check_eq({tag, "_burst"}, {48'd0, conf_burst[c*16 +: 16]}, {48'd0, burst});
      check_eq({tag, "_step"},  {32'd0, conf_step[c*32 +: 32]}, {32'd0, stp});
      check_eq({tag, "_bnum"},  {48'd0, conf_burst_num[c*16 +: 16]}, {48'd0, bnum});
   endtask

   initial begin
      logic [63:0] w;
      logic [63:0] w2;
      rst = 1'b1;
      ins_valid = 1'b0; ins = 64'd0;
      rx_ins_ready = 1'b1; conf_ready = 2'b11;
      in_img_width = 8'd8; out_img_width = 8'd4;
      in_ch_seg = 4'd2; out_ch_seg = 4'd3;
      repeat (3) step();
      rst = 1'b0;
      #1;
      check_eq("rst_ins_ready", {63'd0, ins_ready}, 64'd1);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_conf_valid", {62'd0, conf_valid}, 64'd0);
      check_eq("rst_rx_valid", {63'd0, rx_ins_valid}, 64'd0);
      check_eq("rst_rx_ins", rx_ins, 64'd0);

      // 1: LIN size=9 on ch1
      w = mk(4'b0100, 6'd1, 12'd0, 8'd9, 32'h1000);
      send(w);
      check_eq("t1_cv_early", {62'd0, conf_valid}, 64'd0);
      check_eq("t1_rx_valid", {63'd0, rx_ins_valid}, 64'd1);
      check_eq("t1_rx_ins", rx_ins, w);
      step();
      check_conf("t1", 1, 32'h1000, 16'd10, 32'd0, 16'd0);
      step();
      check_eq("t1_done_cv", {62'd0, conf_valid}, 64'd0);
      check_eq("t1_done_busy", {63'd0, busy}, 64'd0);
      check_eq("t1_done_rdy", {63'd0, ins_ready}, 64'd1);

      // 2: IMG-in pix=1 row=3 on ch0
      send(mk(4'b0000, 6'd0, 12'h031, 8'd0, 32'h2000));
      step();
      check_conf("t2", 0, 32'h2000, 16'd128, 32'd512, 16'd3);
      step();
      check_eq("t2_single", {62'd0, conf_valid}, 64'd0);

      // IMG-out pix=0 row=5, buf_id=3 -> ch1
      send(mk(4'b1000, 6'd3, 12'h050, 8'd0, 32'h3000));
      step();
      check_conf("img_out", 1, 32'h3000, 16'd96, 32'd128, 16'd5);
      step();

      // LIN 0101: len=p_size (no TD_RATE), buf_id=3 -> ch1
      send(mk(4'b0101, 6'd3, 12'd5, 8'd0, 32'h3100));
      step();
      check_conf("lin_p5", 1, 32'h3100, 16'd5, 32'd0, 16'd0);
      step();

      // LIN len=0: no config, instruction still forwarded
      w = mk(4'b0101, 6'd1, 12'd0, 8'd0, 32'h3200);
      send(w);
      check_eq("len0_rx_ins", rx_ins, w);
      step();
      check_eq("len0_cv", {62'd0, conf_valid}, 64'd0);
      check_eq("len0_busy", {63'd0, busy}, 64'd0);

      // size=255 -> exactly MAX_BURST in one config
      send(mk(4'b0100, 6'd0, 12'd0, 8'd255, 32'h8000));
      step();
      check_conf("max", 0, 32'h8000, 16'd256, 32'd0, 16'd0);
      step();
      check_eq("max_single", {62'd0, conf_valid}, 64'd0);

      // 3: p_size=300 * TD_RATE=2 = 600 beats -> 256,256,88
      send(mk(4'b0110, 6'd1, 12'd300, 8'd0, 32'h4000));
      step();
      check_conf("t3a", 1, 32'h4000, 16'd256, 32'd0, 16'd0);
      step();
      check_conf("t3b", 1, 32'h4100, 16'd256, 32'd0, 16'd0);
      step();
      check_conf("t3c", 1, 32'h4200, 16'd88, 32'd0, 16'd0);
      step();
      check_eq("t3_end", {62'd0, conf_valid}, 64'd0);

      // 4: stall 10 cycles on ch0; ready on ch1 must be ignored
      conf_ready = 2'b10;
      send(mk(4'b0100, 6'd0, 12'd0, 8'd3, 32'h5000));
      step();
      check_conf("t4", 0, 32'h5000, 16'd4, 32'd0, 16'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         check_eq("t4_hold_cv", {62'd0, conf_valid}, 64'd1);
         check_eq("t4_hold_addr", {32'd0, conf_st_addr[31:0]}, 64'h5000);
         check_eq("t4_hold_burst", {48'd0, conf_burst[15:0]}, 64'd4);
         check_eq("t4_hold_rdy", {63'd0, ins_ready}, 64'd0);
      end
`ifdef DDR_RD_CONF_PERF_EN
      check_eq("t4_stall_cnt", {32'd0, perf_stall_cnt}, 64'd10);
`endif
      conf_ready = 2'b11;
      step();
      check_eq("t4_release_cv", {62'd0, conf_valid}, 64'd0);
      check_eq("t4_release_busy", {63'd0, busy}, 64'd0);

      // 5: rx slot blocks the next instruction
      rx_ins_ready = 1'b0;
      w = mk(4'b0100, 6'd1, 12'd0, 8'd1, 32'h6000);
      send(w);
      step();
      check_conf("t5", 1, 32'h6000, 16'd2, 32'd0, 16'd0);
      step();
      check_eq("t5_idle", {63'd0, busy}, 64'd0);
      check_eq("t5_blocked", {63'd0, ins_ready}, 64'd0);
      w2 = mk(4'b0100, 6'd0, 12'd0, 8'd7, 32'h6100);
      ins = w2;
      ins_valid = 1'b1;
      repeat (3) step();
      check_eq("t5_no_accept_rx", rx_ins, w);
      check_eq("t5_no_accept_busy", {63'd0, busy}, 64'd0);
      check_eq("t5_rx_held", {63'd0, rx_ins_valid}, 64'd1);
      ins_valid = 1'b0;
      rx_ins_ready = 1'b1;
      step();
      check_eq("t5_rx_clear", {63'd0, rx_ins_valid}, 64'd0);
      check_eq("t5_rdy_back", {63'd0, ins_ready}, 64'd1);
      w = mk(4'b1100, 6'd0, 12'd0, 8'd0, 32'h7000);
      send(w);
      check_eq("t5_op11_rx", rx_ins, w);
      check_eq("t5_op11_rxv", {63'd0, rx_ins_valid}, 64'd1);
      step();
      check_eq("t5_op11_cv", {62'd0, conf_valid}, 64'd0);
      check_eq("t5_op11_busy", {63'd0, busy}, 64'd0);
      check_eq("t5_op11_rdy", {63'd0, ins_ready}, 64'd1);

      // 6: reset during second sub-burst of the 600-beat transfer
      send(mk(4'b0110, 6'd1, 12'd300, 8'd0, 32'h4000));
      step();
      check_conf("t6a", 1, 32'h4000, 16'd256, 32'd0, 16'd0);
      step();
      check_conf("t6b", 1, 32'h4100, 16'd256, 32'd0, 16'd0);
`ifdef DDR_RD_CONF_PERF_EN
      check_eq("perf_ins_cnt", {32'd0, perf_ins_cnt}, 64'(n_sent));
`endif
      rst = 1'b1;
      step();
      check_eq("t6_cv", {62'd0, conf_valid}, 64'd0);
      check_eq("t6_busy", {63'd0, busy}, 64'd0);
      check_eq("t6_rxv", {63'd0, rx_ins_valid}, 64'd0);
      check_eq("t6_rx_ins", rx_ins, 64'd0);
`ifdef DDR_RD_CONF_PERF_EN
      check_eq("t6_perf_ins", {32'd0, perf_ins_cnt}, 64'd0);
      check_eq("t6_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
`endif
      rst = 1'b0;
      #1;
      check_eq("t6_rdy", {63'd0, ins_ready}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("t6_quiet", {62'd0, conf_valid}, 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
